// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C register-transaction master: START, device ID, R/W, memory address, one data byte, STOP.
// Optional macro I2C_MASTER_NACK_ABORT_EN: a NACK jumps straight to STOP at the next slot boundary.
module i2c_master_ctrl #(
  parameter int   CLK_DIV   = 4,
  parameter logic ACK_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic       rw_in,
  input  logic [7:0] mem_addr,
  input  logic [7:0] wdata,
  inout  wire        SDA,
  output logic       SCL,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] state
);
  localparam logic [3:0] S_IDLE = 4'd0, S_START = 4'd1, S_ADDR = 4'd2, S_RW   = 4'd3, S_ACK1 = 4'd4,
                         S_MEM  = 4'd5, S_ACK2  = 4'd6, S_DATA = 4'd7, S_ACK3 = 4'd8, S_STOP = 4'd9;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
`ifdef I2C_MASTER_NACK_ABORT_EN
  localparam logic ABORT_ON_NACK = 1'b1;
`else
  localparam logic ABORT_ON_NACK = 1'b0;
`endif

  logic [3:0]    state_reg, state_next;
  logic [DW-1:0] div_reg;
  logic [1:0]    qtr_reg;
  logic [2:0]    bit_reg;
  logic [6:0]    dev_reg;
  logic          rw_reg;
  logic [7:0]    mem_reg, wd_reg, rdata_reg;
  logic          smp_reg, err_reg, done_reg;
  logic          sda_low, scl_next;
  logic          accept, qtick, slot_end, smp_pt, nack, ack_checked;

  assign busy     = (state_reg != S_IDLE);
  assign accept   = start && (state_reg == S_IDLE);
  assign qtick    = busy && (div_reg == DIV_LAST);
  assign slot_end = qtick && (qtr_reg == 2'd3);
  assign smp_pt   = qtick && (qtr_reg == 2'd2);
  assign nack     = (smp_reg != ACK_LEVEL);
  // Read-data ACK3 belongs to the master's own NACK, so it never flags an error.
  assign ack_checked = (state_reg == S_ACK1) || (state_reg == S_ACK2) || ((state_reg == S_ACK3) && !rw_reg);

  assign SDA   = sda_low ? 1'b0 : 1'bz;
  assign SCL   = scl_next;
  assign rdata = rdata_reg;
  assign done  = done_reg;
  assign err   = err_reg;
  assign state = state_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_START;
      S_START: if (slot_end) state_next = S_ADDR;
      S_ADDR:  if (slot_end && bit_reg == 3'd0) state_next = S_RW;
      S_RW:    if (slot_end) state_next = S_ACK1;
      S_ACK1:  if (slot_end) state_next = (ABORT_ON_NACK && nack) ? S_STOP : S_MEM;
      S_MEM:   if (slot_end && bit_reg == 3'd0) state_next = S_ACK2;
      S_ACK2:  if (slot_end) state_next = (ABORT_ON_NACK && nack) ? S_STOP : S_DATA;
      S_DATA:  if (slot_end && bit_reg == 3'd0) state_next = S_ACK3;
      S_ACK3:  if (slot_end) state_next = S_STOP;
      S_STOP:  if (slot_end) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Data slots: SCL low for Q0-Q1, high for Q2-Q3; SDA only depends on slot-constant registers.
  always_comb begin
    scl_next = 1'b1;
    sda_low  = 1'b0;
    case (state_reg)
      S_START: sda_low = qtr_reg[1];
      S_ADDR:  begin scl_next = qtr_reg[1]; sda_low = !dev_reg[bit_reg]; end
      S_RW:    begin scl_next = qtr_reg[1]; sda_low = !rw_reg; end
      S_MEM:   begin scl_next = qtr_reg[1]; sda_low = !mem_reg[bit_reg]; end
      S_DATA:  begin scl_next = qtr_reg[1]; sda_low = !rw_reg && !wd_reg[bit_reg]; end
      S_ACK1, S_ACK2, S_ACK3: scl_next = qtr_reg[1];
      S_STOP:  begin scl_next = (qtr_reg != 2'd0); sda_low = (qtr_reg != 2'd3); end
      default: begin scl_next = 1'b1; sda_low = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg   <= '0;
      qtr_reg   <= '0;
      bit_reg   <= '0;
      dev_reg   <= '0;
      rw_reg    <= 1'b0;
      mem_reg   <= '0;
      wd_reg    <= '0;
      rdata_reg <= '0;
      smp_reg   <= 1'b0;
      err_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= (state_reg == S_STOP) && slot_end;
      if (accept) begin
        dev_reg <= dev_addr;
        rw_reg  <= rw_in;
        mem_reg <= mem_addr;
        wd_reg  <= wdata;
        err_reg <= 1'b0;
        div_reg <= '0;
        qtr_reg <= '0;
        bit_reg <= '0;
      end else if (busy) begin
        div_reg <= qtick ? '0 : div_reg + 1'b1;
        if (qtick) qtr_reg <= qtr_reg + 2'd1;
        if (smp_pt) begin
          smp_reg <= SDA;
          if (state_reg == S_DATA && rw_reg) rdata_reg <= {rdata_reg[6:0], SDA};
        end
        if (slot_end) begin
          case (state_reg)
            S_START:               bit_reg <= 3'd6;
            S_ADDR, S_MEM, S_DATA: bit_reg <= bit_reg - 3'd1;
            default:               bit_reg <= 3'd7;
          endcase
          if (ack_checked && nack) err_reg <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench: two masters (CLK_DIV=4 standard-ACK, CLK_DIV=1 team-ACK) on pulled-up open-drain buses,
// with a time-scheduled slave model driving ACK and read bits low.
module tb_i2c_master_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] dev_addr = '0;
  logic       rw_in = 1'b0;
  logic [7:0] mem_addr = '0;
  logic [7:0] wdata = '0;
  logic       sel = 1'b0;
  logic       drv = 1'b0;
  int         checks = 0;
  int         failures = 0;

  wire        sda0, sda1;
  logic       scl0, scl1, busy0, busy1, done0, done1, err0, err1;
  logic [7:0] rdata0, rdata1;
  logic [3:0] state0, state1;
  logic       start0, start1;

  pullup (sda0);
  pullup (sda1);
  assign sda0   = (drv && !sel) ? 1'b0 : 1'bz;
  assign sda1   = (drv && sel) ? 1'b0 : 1'bz;
  assign start0 = start && !sel;
  assign start1 = start && sel;

  wire       sda_v   = sel ? sda1 : sda0;
  wire       scl_v   = sel ? scl1 : scl0;
  wire       busy_v  = sel ? busy1 : busy0;
  wire       done_v  = sel ? done1 : done0;
  wire       err_v   = sel ? err1 : err0;
  wire [7:0] rdata_v = sel ? rdata1 : rdata0;
  wire [3:0] state_v = sel ? state1 : state0;

  i2c_master_ctrl #(.CLK_DIV(4), .ACK_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset_n), .start(start0), .dev_addr(dev_addr), .rw_in(rw_in), .mem_addr(mem_addr),
    .wdata(wdata), .SDA(sda0), .SCL(scl0), .rdata(rdata0), .busy(busy0), .done(done0), .err(err0), .state(state0));

  i2c_master_ctrl #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset_n), .start(start1), .dev_addr(dev_addr), .rw_in(rw_in), .mem_addr(mem_addr),
    .wdata(wdata), .SDA(sda1), .SCL(scl1), .rdata(rdata1), .busy(busy1), .done(done1), .err(err1), .state(state1));

  always #5 clk = ~clk;

`ifdef I2C_MASTER_NACK_ABORT_EN
  localparam int NACK_DONE = 176;
  localparam bit NACK_FULL = 1'b0;
`else
  localparam int NACK_DONE = 464;
  localparam bit NACK_FULL = 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ack: slave pulls SDA low in ACK slots. sdat: byte the slave returns on a read.
  task automatic run_txn(input string name, input bit s, input logic [6:0] dv, input logic r, input logic [7:0] ma,
                         input logic [7:0] wd, input bit ack, input logic [7:0] sdat, input int exp_done,
                         input logic exp_err, input bit chk_stream, input bit glitch);
    int q, sp, slot, ph, stop_slot, done_n, ndone;
    logic [28:0] stream, es;
    logic ackbit;
    q = s ? 1 : 4;
    sp = 4 * q;
    stop_slot = exp_done / sp - 1;
    ackbit = ack ? 1'b0 : 1'b1;
    es = {1'b0, dv, r, ackbit, ma, ackbit, (r ? sdat : wd), (r ? 1'b1 : ackbit), 1'b0};
    stream = '0;
    done_n = -1;
    ndone = 0;
    @(negedge clk);
    sel = s; dev_addr = dv; rw_in = r; mem_addr = ma; wdata = wd; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < exp_done + sp + 8; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      slot = n / sp;
      ph = n % sp;
      if (glitch && n == 100) begin
        dev_addr = ~dv; mem_addr = ~ma; wdata = ~wd; rw_in = ~r; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      drv = (ack && (slot == 9 || slot == 18 || (slot == 27 && !r))) ||
            (r && slot >= 19 && slot <= 26 && !sdat[26 - slot]);
      @(negedge clk);
      if (n == 0) chk({name, " start_q0 busy/state/scl/sda"}, {busy_v, state_v, scl_v, sda_v}, 7'b1_0001_11);
      if (n == sp + 1) chk({name, " addr_q0 scl"}, scl_v, 1'b0);
      if (slot < 29 && ph == 2 * q) stream[28 - slot] = sda_v;
      if (n == stop_slot * sp) chk({name, " stop_q0 scl/sda"}, {scl_v, sda_v}, 2'b00);
      if (n == stop_slot * sp + q) chk({name, " stop_q1 scl/sda"}, {scl_v, sda_v}, 2'b10);
      if (n == stop_slot * sp + 3 * q) chk({name, " stop_q3 scl/sda"}, {scl_v, sda_v}, 2'b11);
      if (done_v) begin
        ndone++;
        if (done_n < 0) done_n = n;
      end
    end
    drv = 1'b0;
    if (chk_stream) chk({name, " sda_stream"}, stream, es);
    chk({name, " done_cycle"}, done_n, exp_done);
    chk({name, " done_count"}, ndone, 1);
    chk({name, " end busy/state/scl"}, {busy_v, state_v, scl_v}, 6'b0_0000_1);
    chk({name, " err"}, err_v, exp_err);
    if (r) chk({name, " rdata"}, rdata_v, sdat);
    $display("txn %s dev=%h rw=%0d mem=%h wdata=%h done_at=%0d err=%0d rdata=%h",
             name, dv, r, ma, wd, done_n, err_v, rdata_v);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset dut0 scl/sda/busy/done/err", {scl0, sda0, busy0, done0, err0}, 5'b11000);
    chk("reset dut0 rdata/state", {rdata0, state0}, 12'h000);
    chk("reset dut1 scl/sda/busy/state", {scl1, sda1, busy1, state1}, 7'b1100000);
    @(negedge clk);
    reset_n = 1'b1;
    $display("txn reset released");

    run_txn("write", 1'b0, 7'h02, 1'b0, 8'h10, 8'hA5, 1'b1, 8'h00, 464, 1'b0, 1'b1, 1'b0);
    run_txn("read", 1'b0, 7'h02, 1'b1, 8'h10, 8'h00, 1'b1, 8'h3C, 464, 1'b0, 1'b1, 1'b0);
    run_txn("nack", 1'b0, 7'h05, 1'b0, 8'h10, 8'hA5, 1'b0, 8'h00, NACK_DONE, 1'b1, NACK_FULL, 1'b0);
    run_txn("busy_start", 1'b0, 7'h02, 1'b0, 8'h10, 8'h5A, 1'b1, 8'h00, 464, 1'b0, 1'b1, 1'b1);

    // Reset during MEM bit 3 (slot 14), then a fresh transfer.
    @(negedge clk);
    sel = 1'b0; dev_addr = 7'h02; rw_in = 1'b0; mem_addr = 8'h10; wdata = 8'hA5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14 * 16 + 6) @(posedge clk);
    #1 chk("midreset pre state", state0, 4'd5);
    #1 reset_n = 1'b0;
    #1;
    chk("midreset scl/sda/busy/done/err", {scl0, sda0, busy0, done0, err0}, 5'b11000);
    chk("midreset state/rdata", {state0, rdata0}, 12'h000);
    $display("txn midreset state=%0d scl=%0d sda=%0d busy=%0d", state0, scl0, sda0, busy0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_txn("after_reset", 1'b0, 7'h02, 1'b0, 8'hC3, 8'h3C, 1'b1, 8'h00, 464, 1'b0, 1'b1, 1'b0);

    run_txn("div1_write", 1'b1, 7'h02, 1'b0, 8'h10, 8'hFF, 1'b0, 8'h00, 116, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
